// File: rtl/mem_responder.sv
// mem_responder: word-wide data-memory slave behind the core's load/store
// alignment logic. The byte lanes are big-endian: mask[3]/wdata[31:24] is
// byte address +0. The handshake is req/ack with one request outstanding and
// a fixed number of wait states before the array access.
//
// Handshake: req is sampled only in IDLE. The request fields are latched at
// that edge and later input changes are ignored. ack is a one-cycle pulse in
// RESP, and rdata/err are valid with it. busy is high from the cycle after
// acceptance through the ack cycle. req is ignored while busy.
//
// Optional feature (macro MEM_RESP_ERR_EN): adds the err port. Non-contiguous
// write masks are then rejected: the write is suppressed and err is flagged
// with ack. Without the macro, every mask is applied lane by lane.
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  mask,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_CNT = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              we_q;
  logic [AW-1:0]     idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        mask_q;
  logic              write_ok;
  logic              accept;
  logic [31:0]       mem [DEPTH];

  // Address bits outside the word index are deliberately ignored (wrap).
  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  assign accept = (state == S_IDLE) && req;

`ifdef MEM_RESP_ERR_EN
  // Only single bytes, aligned halfwords, the full word or nothing are legal.
  function automatic logic legal_mask(input logic [3:0] m);
    case (m)
      4'b1000, 4'b0100, 4'b0010, 4'b0001,
      4'b1100, 4'b0011, 4'b1111, 4'b0000: legal_mask = 1'b1;
      default:                            legal_mask = 1'b0;
    endcase
  endfunction

  logic err_q;

  assign write_ok = legal_mask(mask_q);

  // Error flag is decided at the access edge and shown only during ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_ACCESS) begin
      err_q <= we_q && !write_ok;
    end
  end

  assign err = err_q && (state == S_RESP);
`else
  assign write_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> WAIT (if any) -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req) state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt == 4'd1) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Wait-state down-counter: loaded on accept, WAIT lasts WAIT_STATES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= WS_CNT;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Latch the request so the in-flight access ignores later input changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
    end else if (accept) begin
      we_q    <= we;
      idx_q   <= addr[AW+1:2];
      wdata_q <= wdata;
      mask_q  <= mask;
    end
  end

  // Array write, one byte lane per mask bit. A reset at the access edge
  // suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_ACCESS) && we_q && write_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Read data register: changes only on a read access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if ((state == S_ACCESS) && !we_q) begin
      rdata <= mem[idx_q];
    end
  end

  assign ack  = (state == S_RESP);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder (default DEPTH=1024, WAIT_STATES=1).
// Expected values are hand-computed from the big-endian lane map.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  mem_responder dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .mask  (mask),
    .rdata (rdata),
    .ack   (ack),
    .busy  (busy)
`ifdef MEM_RESP_ERR_EN
    ,
    .err   (err)
`endif
  );

`ifndef MEM_RESP_ERR_EN
  assign err = 1'b0;
`endif

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: issue one request, scramble inputs after acceptance, wait for ack.
  // lat counts cycles after the accept cycle (0 = no ack within budget).
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] rd,
                     output logic er, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; mask = m;
    @(negedge clk);
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d; mask = ~m;
    lat = 0; rd = 32'd0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (ack) begin
        lat = k; rd = rdata; er = err;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n_acks;
  int          ack_pos [4];
  int          busy_low;
  int          bad_low;
  logic        prev_ack;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; mask = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // T1: full-word write then read, latency 3
    txn(1'b1, 32'h10, 32'h11223344, 4'b1111, rd, er, lat);
    check("t1_wr_lat", lat, 32'd3);
    check("t1_wr_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    check("t1_rd_lat", lat, 32'd3);
    check("t1_rd_data", rd, 32'h11223344);

    // T2: single byte lane at +1; rdata holds across the write
    txn(1'b1, 32'h11, 32'h00AA0000, 4'b0100, rd, er, lat);
    check("t2_wr_lat", lat, 32'd3);
    check("t2_rdata_hold", rdata, 32'h11223344);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    check("t2_rd_data", rd, 32'h11AA3344);

    // T3: low halfword; addr[1:0] ignored on read
    txn(1'b1, 32'h12, 32'h0000BEEF, 4'b0011, rd, er, lat);
    txn(1'b0, 32'h13, 32'h0, 4'b0000, rd, er, lat);
    check("t3_rd_data", rd, 32'h11AABEEF);

    // Empty mask: ack given, no change
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    check("mask0_lat", lat, 32'd3);
    check("mask0_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    check("mask0_rd", rd, 32'h11AABEEF);

    // Address wrap: index is modulo DEPTH
    txn(1'b1, 32'h0, 32'h12345678, 4'b1111, rd, er, lat);
    txn(1'b0, 32'h1000, 32'h0, 4'b0000, rd, er, lat);
    check("wrap_rd0", rd, 32'h12345678);
    txn(1'b1, 32'h1004, 32'hCAFEF00D, 4'b1111, rd, er, lat);
    txn(1'b0, 32'h4, 32'h0, 4'b0000, rd, er, lat);
    check("wrap_rd4", rd, 32'hCAFEF00D);

    // T4: req held through cycles 0..11; accepts every 4 cycles (WS+3)
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; mask = 4'b0000;
    n_acks = 0; busy_low = 0; bad_low = 0; prev_ack = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (ack) begin
        if (n_acks < 4) ack_pos[n_acks] = j;
        n_acks++;
        check("t4_rdata", rdata, 32'h11AABEEF);
      end
      if (!busy) begin
        busy_low++;
        if (!prev_ack) bad_low++;
      end
      prev_ack = ack;
    end
    req = 1'b0;
    check("t4_n_acks", n_acks, 32'd3);
    check("t4_ack0", ack_pos[0], 32'd3);
    check("t4_ack1", ack_pos[1], 32'd7);
    check("t4_ack2", ack_pos[2], 32'd11);
    check("t4_busy_low", busy_low, 32'd2);
    check("t4_bad_low", bad_low, 32'd0);
    @(negedge clk);
    check("t4_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t4_no_reaccept", {31'd0, busy}, 32'd0);

    // T5: reset during WAIT aborts the write
    txn(1'b1, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    txn(1'b1, 32'h24, 32'h0, 4'b1111, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hDEADBEEF; mask = 4'b1111;
    @(negedge clk);
    req = 1'b0;
    check("t5_busy_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ack", {31'd0, ack}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_rdata", rdata, 32'd0);
    check("t5_rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    n_acks = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (ack) n_acks++;
    end
    check("t5_no_ack", n_acks, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
    check("t5_rd20", rd, 32'h00000000);

    // Reset in the ACCESS cycle: write must not commit
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'h55555555; mask = 4'b1111;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("acc_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    txn(1'b0, 32'h24, 32'h0, 4'b0000, rd, er, lat);
    check("acc_rst_rd24", rd, 32'h00000000);

    // T6: non-contiguous mask 0110
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0110, rd, er, lat);
    check("t6_wr_lat", lat, 32'd3);
`ifdef MEM_RESP_ERR_EN
    check("t6_err", {31'd0, er}, 32'd1);
    @(negedge clk);
    check("t6_err_after", {31'd0, err}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    check("t6_rd", rd, 32'h11AABEEF);
    check("t6_rd_err", {31'd0, er}, 32'd0);
`else
    txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    check("t6_rd", rd, 32'h11FFFFEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
